// File: rtl/rv32i_amo_sequencer.sv
// AMOADD.W sequencer: reads one memory word, adds rs2 through the shared ALU,
// writes the sum back and returns the old value to rd.
module rv32i_amo_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        amo_start,
  input  logic [31:0] amo_addr,
  input  logic [31:0] amo_rs2,
  input  logic [4:0]  amo_rd,
  output logic        stall,
  output logic        busy,
  output logic        alu_src,
  output logic        alu_a_sel,
  input  logic [31:0] alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_ADD,
    S_WR,
    S_DONE
  } state_t;

  // Last wait cycle index before an access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic [7:0]  wait_q;
  logic        misalign_q;
  logic        bus_err_q;
  logic        accept;
  logic        misalign_hit;
  logic        timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    misalign_hit = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (amo_start) begin
          if (amo_addr[1:0] != 2'b00) begin
            misalign_hit = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ready) begin
          state_d = S_ADD;
        end else if (wait_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ADD: begin
        state_d = S_WR;
      end
      S_WR: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latches, wait counter and the two exception pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
      wait_q     <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= misalign_hit;
      bus_err_q  <= timeout_hit;
      if (accept) begin
        addr_q <= amo_addr;
        rs2_q  <= amo_rs2;
        rd_q   <= amo_rd;
      end
      if (state_q == S_RD && mem_ready) begin
        old_q <= mem_rdata;
      end
      if (state_q == S_ADD) begin
        new_q <= alu_result;
      end
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if ((state_q == S_RD || state_q == S_WR) && !mem_ready) begin
        wait_q <= wait_q + 8'd1;
      end
    end
  end

  always_comb begin
    stall     = (state_q != S_IDLE);
    busy      = (state_q != S_IDLE);
    alu_src   = 1'b0;
    alu_a_sel = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_we     = 1'b0;
    rd_waddr  = '0;
    rd_wdata  = '0;
    case (state_q)
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      S_ADD: begin
        alu_a_sel = 1'b1;
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = new_q;
      end
      S_DONE: begin
        rd_we    = (rd_q != 5'd0);
        rd_waddr = rd_q;
        rd_wdata = old_q;
      end
      default: begin
      end
    endcase
  end

  assign misalign_exc = misalign_q;
  assign bus_err      = bus_err_q;

  // The ALU reads rs2 straight from the frozen EX stage, so it must match the latched copy.
  rs2_held_during_add: assert property (
    @(posedge clk) disable iff (rst) (state_q == S_ADD) |-> (amo_rs2 == rs2_q)
  );

endmodule
